gshare_global_pred: RTL
=======================

Name: gshare_global_pred

Overview:
- Global-history branch predictor in the Decode stage of the 5-stage MIPS pipeline; directly upstream of the tournament chooser.
- For each D-stage branch it hashes pcD with a speculative global history register (GHR) and reads a 2-bit saturating PHT counter. The result is the chooser's globalpred input.
- Trains the PHT and repairs the GHR when the branch resolves in M.
- The GHR snapshot used at D is exported so the pipeline can carry it to M.

Parameters:
- PHT_DEPTH, 6, log2 of PHT entries; also the GHR width.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- branchD  input  1  instruction in D is a conditional branch.
- stallD  input  1  D stage is stalled this cycle.
- pcD  input  32  PC of the D-stage instruction.
- final_predD  input  1  chooser's final taken prediction for the D-stage branch.
- globalpred  output  1  global prediction for pcD; goes to the chooser.
- ghrD  output  PHT_DEPTH  speculative GHR value used to form this cycle's index; piped to M.
- branchM  input  1  instruction in M is a conditional branch.
- pcM  input  32  PC of the M-stage branch.
- ghrM  input  PHT_DEPTH  ghrD snapshot carried down with the M-stage branch.
- actual_takeM  input  1  resolved direction.
- mispredM  input  1  final prediction for the M-stage branch was wrong (pipeline flush in progress).

Behaviour:
- Storage:
  - PHT: 2^PHT_DEPTH entries of 2 bits each.
  - Encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
  - GHR: PHT_DEPTH bits, with the newest outcome in bit 0.
- Reset (synchronous, rst=1 at posedge clk):
  - Every PHT entry goes to 01 and the GHR goes to 0.
  - Reset overrides every update in the same cycle.
  - After reset, globalpred=0 and ghrD=0.
- Read (combinational, zero latency):
  - idxD = pcD[PHT_DEPTH+1:2] XOR ghr.
  - globalpred = PHT[idxD][1].
  - ghrD = ghr.
  - Outputs are valid whether or not branchD is asserted.
- PHT update at posedge clk when branchM=1:
  - idxM = pcM[PHT_DEPTH+1:2] XOR ghrM.
  - actual_takeM=1: increment the counter, saturating at 11.
  - actual_takeM=0: decrement the counter, saturating at 00.
  - branchM=0: no PHT write.
- Read/write to the same index in the same cycle: globalpred shows the pre-write value; the new value is visible from the next cycle.
- GHR update at posedge clk, priority high to low:
  1. rst: ghr <= 0.
  2. branchM & mispredM: ghr <= {ghrM[PHT_DEPTH-2:0], actual_takeM}. This is the repair; the concurrent D-stage shift is discarded because that branch is on the wrong path.
  3. branchD & ~stallD: ghr <= {ghr[PHT_DEPTH-2:0], final_predD}. This is the speculative shift.
  4. Otherwise ghr holds.
- Stall: while stallD=1 the GHR is unchanged, so globalpred and ghrD stay stable for a stalled branch. M-stage training and repair still proceed during a stall.
- A correctly predicted M-stage branch does not touch the GHR; its outcome was already shifted in speculatively at D.
- Index arithmetic: pure bitwise XOR of equal widths. PC bits [1:0] are ignored, and PC bits above PHT_DEPTH+1 alias.

Test Plan:
- Reset: assert rst one cycle, then pcD=0x00400000 with branchD=0 → globalpred=0, ghrD=0; any PHT entry read gives 01.
- Training saturation:
  - Step 1: branchM=1, pcM=0x00400010, ghrM=0, actual_takeM=1, mispredM=0 for 3 cycles.
  - Step 1 response: with pcD=0x00400010 and ghr=0, globalpred becomes 1 after the 1st update. Counter path 01→10→11, holding at 11.
  - Step 2: 3 not-taken updates → path 11→10→01→00, with globalpred=0 after the 2nd.
- Speculative shift: ghr=0, branchD=1, stallD=0, final_predD=1 for 2 cycles → ghrD=000001, then 000011. The same stimulus with stallD=1 leaves ghrD=0.
- Mispredict repair with collision:
  - Stimulus: ghr=0b101010, ghrM=0b000111, actual_takeM=0, branchM=1, mispredM=1. In the same cycle branchD=1, final_predD=1.
  - Required response: next ghrD=0b001110, i.e. the D-stage shift is dropped.
- Same-cycle read/write:
  - Setup: pcD=pcM=0x00400020, ghr=ghrM=0, entry at 01.
  - Stimulus: taken update.
  - Required response: globalpred=0 in the update cycle and 1 in the following cycle.
- Reset mid-operation: assert rst while branchM=1, mispredM=1 and branchD=1 → next cycle ghrD=0 and all PHT entries are 01; no update is applied.

Source files
------------

// File: rtl/gshare_global_pred.sv
// gshare global-history direction predictor for the Decode stage.
// Trains its PHT and repairs the speculative GHR from the Memory stage.
module gshare_global_pred #(
  parameter int PHT_DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branchD,
  input  logic                 stallD,
  input  logic [31:0]          pcD,
  input  logic                 final_predD,
  output logic                 globalpred,
  output logic [PHT_DEPTH-1:0] ghrD,
  input  logic                 branchM,
  input  logic [31:0]          pcM,
  input  logic [PHT_DEPTH-1:0] ghrM,
  input  logic                 actual_takeM,
  input  logic                 mispredM
);

  localparam int Entries = 1 << PHT_DEPTH;

  logic [1:0]           pht [Entries];
  logic [PHT_DEPTH-1:0] ghr;
  logic [PHT_DEPTH-1:0] ghrNext;
  logic [PHT_DEPTH-1:0] idxD;
  logic [PHT_DEPTH-1:0] idxM;
  logic [1:0]           ctrM;
  logic [1:0]           ctrNext;
  logic                 repair;
  logic                 shift;
  logic                 unusedPc;

  assign idxD = pcD[PHT_DEPTH+1:2] ^ ghr;
  assign idxM = pcM[PHT_DEPTH+1:2] ^ ghrM;

  assign globalpred = pht[idxD][1];
  assign ghrD       = ghr;
  assign ctrM       = pht[idxM];

  // PC bits outside the index field alias by design.
  assign unusedPc = ^{pcD[31:PHT_DEPTH+2], pcD[1:0],
                      pcM[31:PHT_DEPTH+2], pcM[1:0]};

  // A wrong-path D-stage shift loses to the M-stage repair.
  assign repair = branchM & mispredM;
  assign shift  = branchD & ~stallD & ~repair;

  // Saturating 2-bit counter step for the resolving branch.
  always_comb begin
    ctrNext = ctrM;
    if (actual_takeM) begin
      if (ctrM != 2'b11) ctrNext = ctrM + 2'd1;
    end else begin
      if (ctrM != 2'b00) ctrNext = ctrM - 2'd1;
    end
  end

  // Next GHR: repair from M, else speculative shift, else hold.
  always_comb begin
    ghrNext = ghr;
    unique case (1'b1)
      repair:  ghrNext = {ghrM[PHT_DEPTH-2:0], actual_takeM};
      shift:   ghrNext = {ghr[PHT_DEPTH-2:0], final_predD};
      default: ghrNext = ghr;
    endcase
  end

  // State update; reset wins over training and history moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) pht[i] <= 2'b01;
      ghr <= '0;
    end else begin
      ghr <= ghrNext;
      if (branchM) pht[idxM] <= ctrNext;
    end
  end

endmodule
